// File: rtl/mem_word_wr_byte_stream_rd.sv
// 256-byte (2**AW) memory: 32-bit word writes with byte enables, byte-wide burst read stream.
// Latency: first byte is presented 1 cycle after an accepted rd_start, then 1 byte per handshake.
// Backpressure: rd_ready=0 holds rd_data/rd_valid/rd_last stable; writes never stall.
// Ports: clk/rst_n; word write port (wr_en, wr_addr, wr_data, wr_be);
//        burst command (rd_start, rd_addr, rd_len) and stream output
//        (rd_busy, rd_data, rd_valid, rd_ready, rd_last).
module mem_word_wr_byte_stream_rd #(
  parameter int AW = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-3:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be,
  input  logic          rd_start,
  input  logic [AW-1:0] rd_addr,
  input  logic [LW-1:0] rd_len,
  output logic          rd_busy,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;    // address of the byte currently presented
  logic [LW-1:0] rem_q, rem_d;    // bytes still to come after the presented one
  logic [7:0]    data_q, data_d;

  logic [7:0]    mem_q [DEPTH];

  logic          fetch_en;
  logic [AW-1:0] fetch_addr;
  logic          fwd_hit;
  logic [7:0]    fetch_byte;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem_q[{wr_addr, 2'(i)}] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // A write landing on the byte being fetched in the same cycle wins over the
  // stored (stale) value, so the stream always sees the post-write memory.
  always_comb begin
    fwd_hit    = wr_en && (wr_addr == fetch_addr[AW-1:2]) && wr_be[fetch_addr[1:0]];
    fetch_byte = mem_q[fetch_addr];
    if (fwd_hit) begin
      fetch_byte = wr_data[{fetch_addr[1:0], 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    fetch_en   = 1'b0;
    fetch_addr = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          fetch_en   = 1'b1;
          fetch_addr = rd_addr;
          ptr_d      = rd_addr;
          rem_d      = rd_len;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        // rd_valid is always 1 here, so rd_ready alone marks a handshake.
        // rd_start is not looked at: a new burst needs a cycle in IDLE.
        if (rd_ready) begin
          if (rem_q == '0) begin
            state_d = IDLE;
          end else begin
            fetch_en   = 1'b1;
            fetch_addr = ptr_q + 1'b1;   // wraps modulo 2**AW
            ptr_d      = fetch_addr;
            rem_d      = rem_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // rd_data is a snapshot: only a fetch changes it.
    data_d = fetch_en ? fetch_byte : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode directly from reset flops, so reset clears them immediately.
  assign rd_busy  = (state_q == STREAM);
  assign rd_valid = (state_q == STREAM);
  assign rd_last  = (state_q == STREAM) && (rem_q == '0);
  assign rd_data  = data_q;

endmodule

// File: tb/tb_mem_word_wr_byte_stream_rd.sv
// Testbench for mem_word_wr_byte_stream_rd: directed bursts plus random traffic,
// a byte-level memory/burst reference model feeding an expected-byte queue,
// and a negedge monitor that pops and compares on every handshake.
module tb_mem_word_wr_byte_stream_rd;

  localparam int AW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-3:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic          rd_start;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_len;
  logic          rd_busy;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;

  mem_word_wr_byte_stream_rd #(.AW(AW), .LW(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_start (rd_start),
    .rd_addr  (rd_addr),
    .rd_len   (rd_len),
    .rd_busy  (rd_busy),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_last  (rd_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic [7:0] exp_bytes[$];

  logic [7:0] mdl_mem [256];
  bit         mdl_busy = 1'b0;
  int         mdl_addr = 0;
  int         mdl_left = 0;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: the memory is a byte array; a burst is "start address,
  // bytes left". Each edge applies the write first, so any byte read at that
  // edge sees the newly written value.
  always @(posedge clk) begin
    exp_t e;
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mdl_mem[wr_addr*4 + i] = wr_data[8*i +: 8];
      end
    end
    if (!rst_n) begin
      mdl_busy = 1'b0;
      exp_q.delete();
    end else if (mdl_busy) begin
      if (rd_ready) begin
        if (mdl_left == 0) begin
          mdl_busy = 1'b0;
        end else begin
          mdl_addr = (mdl_addr + 1) % 256;
          mdl_left--;
          e.d = mdl_mem[mdl_addr];
          e.l = (mdl_left == 0);
          exp_q.push_back(e);
        end
      end
    end else if (rd_start) begin
      mdl_busy = 1'b1;
      mdl_addr = int'(rd_addr);
      mdl_left = int'(rd_len);
      e.d = mdl_mem[mdl_addr];
      e.l = (mdl_left == 0);
      exp_q.push_back(e);
    end
  end

  // Monitor: the head of exp_q is the byte that must be on the port now.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", rd_busy, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_last", rd_last, 0);
      chk("rst_data", rd_data, 0);
    end else begin
      chk("valid", rd_valid, exp_q.size() > 0);
      chk("busy", rd_busy, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("data", rd_data, exp_q[0].d);
        chk("last", rd_last, exp_q[0].l);
        if (rd_ready) begin
          got_d.push_back(rd_data);
          got_l.push_back(rd_last);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-3:0] wa, input logic [31:0] d, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_addr = wa;
    wr_data = d;
    wr_be   = be;
    tick();
    wr_en   = 1'b0;
    wr_be   = 4'h0;
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [LW-1:0] l);
    got_d.delete();
    got_l.delete();
    rd_addr  = a;
    rd_len   = l;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    bit done = 1'b0;
    rd_start = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (!mdl_busy) begin
        done = 1'b1;
      end else begin
        rd_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        tick();
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout: burst still busy=%0d expected 0", mdl_busy);
    end
    rd_ready = 1'b1;
  endtask

  task automatic cmp_got(input string nm);
    chk({nm, "_count"}, got_d.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < got_d.size(); i++) begin
      chk(nm, got_d[i], exp_bytes[i]);
      chk({nm, "_last"}, got_l[i], i == exp_bytes.size() - 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] vseq;
    int          nlast;

    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_be    = 4'h0;
    rd_start = 1'b0;
    rd_addr  = '0;
    rd_len   = '0;
    rd_ready = 1'b0;

    // Reset held with random read-side activity.
    for (int i = 0; i < 5; i++) begin
      rd_start = 1'($urandom);
      rd_addr  = 8'($urandom);
      rd_len   = 8'($urandom);
      rd_ready = 1'($urandom);
      tick();
    end
    rd_start = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int w = 0; w < 64; w++) wr(6'(w), 32'h0, 4'hF);

    // Word write, byte stream.
    wr(6'd0, 32'h4433_2211, 4'hF);
    start(8'd0, 8'd3);
    drain(1'b0);
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    cmp_got("burst_word0");
    chk("busy_after_burst", rd_busy, 0);

    // Partial byte enables and address wrap.
    wr(6'd63, 32'hDDCC_BBAA, 4'b0101);
    start(8'd252, 8'd5);
    drain(1'b0);
    exp_bytes = '{8'hAA, 8'h00, 8'hCC, 8'h00, 8'h11, 8'h22};
    cmp_got("burst_wrap");

    // Backpressure on the second byte.
    start(8'd0, 8'd3);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("stall_data", rd_data, 8'h22);
    chk("stall_valid", rd_valid, 1);
    drain(1'b0);
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    cmp_got("burst_stall");

    // Forwarding on the fetch edge, then a write to the stalled byte.
    start(8'd0, 8'd3);
    rd_ready = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = 6'd0;
    wr_be    = 4'b0010;
    wr_data  = 32'h0000_5A00;
    tick();
    chk("fwd_data", rd_data, 8'h5A);
    rd_ready = 1'b0;
    wr_data  = 32'h0000_A500;
    tick();
    wr_en = 1'b0;
    wr_be = 4'h0;
    tick();
    chk("snapshot_data", rd_data, 8'h5A);
    drain(1'b0);
    exp_bytes = '{8'h11, 8'h5A, 8'h33, 8'h44};
    cmp_got("burst_fwd");

    // rd_start held high: one idle cycle between back-to-back 3-byte bursts.
    rd_addr  = 8'd8;
    rd_len   = 8'd2;
    rd_ready = 1'b1;
    rd_start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      vseq[i] = rd_valid;
    end
    chk("start_held_pattern", vseq, 12'h777);
    drain(1'b0);

    // Maximum length burst.
    start(8'($urandom), 8'd255);
    drain(1'b1);
    nlast = 0;
    foreach (got_l[i]) if (got_l[i]) nlast++;
    chk("maxlen_count", got_d.size(), 256);
    chk("maxlen_nlast", nlast, 1);
    if (got_l.size() == 256) chk("maxlen_last_pos", got_l[255], 1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = 6'($urandom);
      wr_data  = $urandom;
      wr_be    = 4'($urandom);
      rd_start = ($urandom_range(0, 4) == 0);
      rd_addr  = 8'($urandom);
      rd_len   = 8'($urandom_range(0, 15));
      rd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    wr_en = 1'b0;
    wr_be = 4'h0;
    drain(1'b1);

    // Asynchronous reset in the middle of a burst.
    start(8'd0, 8'd10);
    rd_ready = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", rd_busy, 0);
    chk("arst_valid", rd_valid, 0);
    chk("arst_last", rd_last, 0);
    chk("arst_data", rd_data, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", rd_busy, 0);
    chk("post_rst_valid", rd_valid, 0);
    start(8'd252, 8'd1);
    drain(1'b0);
    exp_bytes = '{mdl_mem[252], mdl_mem[253]};
    cmp_got("burst_after_rst");

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
